// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 RAM programming path.
// Holds the loader state encoding and the RAM geometry used by the
// loader and its debouncers.
package sap1_pkg;

    localparam int SAP1_ADDR_W    = 4;
    localparam int SAP1_DATA_W    = 8;
    localparam int SAP1_RAM_DEPTH = 16;

    typedef enum logic [2:0] {
        RUN,
        PROG,
        MAN_WR,
        STREAM,
        DONE
    } loader_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Synchronizer plus stability filter for one raw front-panel input.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   raw       - unsynchronized switch/button level
//   debounced - accepted level; follows the synchronized input only after
//               DebounceDelay consecutive equal samples
module input_debouncer #(
    parameter int DebounceDelay = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic debounced
);

    localparam int CntW = (DebounceDelay > 1) ? $clog2(DebounceDelay) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(DebounceDelay - 1);

    logic [1:0]      syncReg;
    logic [CntW-1:0] stableCnt;

    // The down-counter measures how long the synchronized level has disagreed
    // with the accepted level; any agreement restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncReg   <= '0;
            stableCnt <= Reload;
            debounced <= 1'b0;
        end else begin
            syncReg <= {syncReg[0], raw};
            if (syncReg[1] == debounced) begin
                stableCnt <= Reload;
            end else if (stableCnt == '0) begin
                debounced <= syncReg[1];
                stableCnt <= Reload;
            end else begin
                stableCnt <= stableCnt - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ram_program_loader.sv
// Programming-side controller for the SAP-1 16x8 RAM. Shares the RAM port
// between the running CPU, the front-panel switches/write button and a
// valid/ready byte-stream loader, and holds the CPU in clear while
// programming.
// Ports:
//   base_clock, CLR                 - clock, async active-high reset
//   S3_ProgRun_sw, S4_Write_pb      - raw prog/run switch and write button
//   S1_Addr_sw, S2_Data_sw          - manual address and data switches
//   stream_valid/data/last, stream_ready - byte-stream handshake
//   cpu_mem_addr, cpu_CE_bar        - CPU-side RAM address and output enable
//   ram_addr, ram_wdata, ram_we, ram_CE_bar - RAM port
//   cpu_hold                        - holds the controller in clear
//   load_done, load_count           - stream load completion pulse and length
//
// state  | meaning
// RUN    | CPU owns the RAM port
// PROG   | programming idle, switch-selected word shown on the W bus
// MAN_WR | one-cycle write of the data switches
// STREAM | accepting stream bytes from address 0 upward
// DONE   | stream load finished, load_done pulse
module ram_program_loader
    import sap1_pkg::*;
#(
    parameter int DebounceDelay = 8,
    parameter int AddrWidth     = SAP1_ADDR_W,
    parameter int DataWidth     = SAP1_DATA_W
) (
    input  logic                 base_clock,
    input  logic                 CLR,
    input  logic                 S3_ProgRun_sw,
    input  logic                 S4_Write_pb,
    input  logic [AddrWidth-1:0] S1_Addr_sw,
    input  logic [DataWidth-1:0] S2_Data_sw,
    input  logic                 stream_valid,
    input  logic [DataWidth-1:0] stream_data,
    input  logic                 stream_last,
    output logic                 stream_ready,
    input  logic [AddrWidth-1:0] cpu_mem_addr,
    input  logic                 cpu_CE_bar,
    output logic [AddrWidth-1:0] ram_addr,
    output logic [DataWidth-1:0] ram_wdata,
    output logic                 ram_we,
    output logic                 ram_CE_bar,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic [AddrWidth:0]   load_count
);

    loader_state_t state, nextState;

    logic progDb, pbDb, pbPrev, pbRise;
    logic holdReg, manWe, readyReg, doneReg;
    logic [AddrWidth:0]   loadCount;
    logic [AddrWidth-1:0] ptr;
    logic accept;

    input_debouncer #(.DebounceDelay(DebounceDelay)) uProgDb (
        .clk       (base_clock),
        .rst       (CLR),
        .raw       (S3_ProgRun_sw),
        .debounced (progDb)
    );

    input_debouncer #(.DebounceDelay(DebounceDelay)) uPbDb (
        .clk       (base_clock),
        .rst       (CLR),
        .raw       (S4_Write_pb),
        .debounced (pbDb)
    );

    assign pbRise = pbDb & ~pbPrev;
    // The write pointer is the low bits of the byte count, so it wraps to 0
    // exactly when the count reaches the RAM depth.
    assign ptr    = loadCount[AddrWidth-1:0];
    assign accept = (state == STREAM) & stream_valid & readyReg;

    always_comb begin
        nextState = state;
        case (state)
            RUN:    if (progDb) nextState = PROG;
            PROG: begin
                if (!progDb)           nextState = RUN;
                else if (pbRise)       nextState = MAN_WR;
                else if (stream_valid) nextState = STREAM;
            end
            MAN_WR: nextState = progDb ? PROG : RUN;
            STREAM: begin
                if (!progDb)                             nextState = RUN;
                else if (accept && (stream_last || &ptr)) nextState = DONE;
            end
            DONE:    nextState = PROG;
            default: nextState = RUN;
        endcase
    end

    always_comb begin
        ram_addr   = cpu_mem_addr;
        ram_CE_bar = cpu_CE_bar;
        ram_wdata  = S2_Data_sw;
        case (state)
            PROG: begin
                ram_addr   = S1_Addr_sw;
                ram_CE_bar = 1'b0;
            end
            MAN_WR: begin
                ram_addr   = S1_Addr_sw;
                ram_CE_bar = 1'b1;
            end
            STREAM, DONE: begin
                ram_addr   = ptr;
                ram_wdata  = stream_data;
                ram_CE_bar = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge base_clock or posedge CLR) begin
        if (CLR) begin
            state     <= RUN;
            pbPrev    <= 1'b0;
            holdReg   <= 1'b0;
            manWe     <= 1'b0;
            readyReg  <= 1'b0;
            doneReg   <= 1'b0;
            loadCount <= '0;
        end else begin
            state    <= nextState;
            pbPrev   <= pbDb;
            holdReg  <= (nextState != RUN);
            manWe    <= (nextState == MAN_WR);
            readyReg <= (nextState == STREAM);
            doneReg  <= (nextState == DONE);
            if (state != STREAM && nextState == STREAM) begin
                loadCount <= '0;
            end else if (accept) begin
                loadCount <= loadCount + (AddrWidth + 1)'(1);
            end
        end
    end

    // Stream writes complete on the handshake edge itself, so the strobe
    // follows stream_valid combinationally while in STREAM.
    assign ram_we       = manWe | accept;
    assign cpu_hold     = holdReg;
    assign stream_ready = readyReg;
    assign load_done    = doneReg;
    assign load_count   = loadCount;

endmodule

// File: tb/tb_ram_program_loader.sv
// Self-checking bench for ram_program_loader: reset/run mux, manual writes,
// bouncy button, stream loads (early last, overflow, random), abort and
// mid-stream reset, checked against a transaction-level RAM model.
module tb_ram_program_loader;

    localparam int DD = 8;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          base_clock = 1'b0;
    logic          CLR;
    logic          S3_ProgRun_sw, S4_Write_pb;
    logic [AW-1:0] S1_Addr_sw;
    logic [DW-1:0] S2_Data_sw;
    logic          stream_valid, stream_last, stream_ready;
    logic [DW-1:0] stream_data;
    logic [AW-1:0] cpu_mem_addr;
    logic          cpu_CE_bar;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we, ram_CE_bar, cpu_hold, load_done;
    logic [AW:0]   load_count;

    always #5 base_clock = ~base_clock;

    ram_program_loader #(.DebounceDelay(DD), .AddrWidth(AW), .DataWidth(DW)) dut (
        .base_clock    (base_clock),
        .CLR           (CLR),
        .S3_ProgRun_sw (S3_ProgRun_sw),
        .S4_Write_pb   (S4_Write_pb),
        .S1_Addr_sw    (S1_Addr_sw),
        .S2_Data_sw    (S2_Data_sw),
        .stream_valid  (stream_valid),
        .stream_data   (stream_data),
        .stream_last   (stream_last),
        .stream_ready  (stream_ready),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_CE_bar    (cpu_CE_bar),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_CE_bar    (ram_CE_bar),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_count    (load_count)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed RAM writes and load_done pulses.
    logic [11:0] wrQ[$];
    int          doneCnt = 0;
    logic [7:0]  obsMem[16];

    always @(negedge base_clock) begin
        if (!CLR) begin
            if (ram_we) begin
                wrQ.push_back({ram_addr, ram_wdata});
                obsMem[ram_addr] = ram_wdata;
            end
            if (load_done) doneCnt++;
        end
    end

    // Reference RAM contents.
    logic [7:0] expMem[16];
    bit         expSet[16];

    task automatic cycles(input int n);
        repeat (n) @(posedge base_clock);
        #1;
    endtask

    task automatic manualWrite(input logic [3:0] a, input logic [7:0] d, input int holdCyc,
                               input string tag);
        int q0;
        q0 = wrQ.size();
        S1_Addr_sw = a;
        S2_Data_sw = d;
        @(negedge base_clock);
        checkVal({tag, "_showAddr"}, ram_addr, a);
        checkVal({tag, "_ceLow"}, ram_CE_bar, 0);
        cycles(1);
        S4_Write_pb = 1'b1;
        cycles(holdCyc);
        S4_Write_pb = 1'b0;
        cycles(14);
        checkVal({tag, "_nWrites"}, wrQ.size() - q0, 1);
        if (wrQ.size() > q0) checkVal({tag, "_wr"}, wrQ[q0], {a, d});
        checkVal({tag, "_hold"}, cpu_hold, 1);
        expMem[a] = d;
        expSet[a] = 1'b1;
    endtask

    // lastPos: 1-based position of the byte carrying stream_last, 0 = none.
    task automatic streamLoad(input int nBytes, input int lastPos, input bit pattern,
                              input bit gaps, input string tag);
        logic [7:0] bytes[20];
        int expN, idx, q0, d0;
        bit acc;
        expN = (lastPos >= 1 && lastPos <= 16) ? lastPos : 16;
        for (int i = 0; i < 20; i++) bytes[i] = pattern ? 8'(i + 1) : 8'($urandom);
        q0  = wrQ.size();
        d0  = doneCnt;
        idx = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            stream_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            stream_data  = bytes[idx];
            stream_last  = (idx + 1 == lastPos);
            @(negedge base_clock);
            acc = stream_valid && stream_ready;
            cycles(1);
            if (acc) idx++;
            if (idx == expN || idx >= nBytes) break;
        end
        if (nBytes > expN) begin
            stream_valid = 1'b1;
            stream_data  = bytes[idx];
            stream_last  = 1'b0;
            @(negedge base_clock);
            checkVal({tag, "_readyAfterEnd"}, stream_ready, 0);
            checkVal({tag, "_donePulse"}, load_done, 1);
            cycles(1);
        end
        stream_valid = 1'b0;
        stream_last  = 1'b0;
        cycles(3);
        checkVal({tag, "_accepted"}, idx, expN);
        checkVal({tag, "_nWrites"}, wrQ.size() - q0, expN);
        for (int i = 0; i < expN; i++) begin
            if (q0 + i < wrQ.size()) checkVal({tag, "_wr"}, wrQ[q0 + i], {4'(i), bytes[i]});
            expMem[i] = bytes[i];
            expSet[i] = 1'b1;
        end
        checkVal({tag, "_loadCount"}, load_count, expN);
        checkVal({tag, "_nDone"}, doneCnt - d0, 1);
        checkVal({tag, "_hold"}, cpu_hold, 1);
        checkVal({tag, "_readyIdle"}, stream_ready, 0);
    endtask

    initial begin
        int q0, d0, idx;
        bit acc;
        CLR = 1'b1;
        S3_ProgRun_sw = 0; S4_Write_pb = 0;
        S1_Addr_sw = '0; S2_Data_sw = '0;
        stream_valid = 0; stream_data = '0; stream_last = 0;
        cpu_mem_addr = 4'hA; cpu_CE_bar = 1'b1;
        for (int i = 0; i < 16; i++) expSet[i] = 1'b0;
        cycles(3);
        CLR = 1'b0;
        cycles(2);

        // Reset then run
        @(negedge base_clock);
        checkVal("run_addr", ram_addr, 4'hA);
        checkVal("run_hold", cpu_hold, 0);
        checkVal("run_ce", ram_CE_bar, 1);
        checkVal("run_ready", stream_ready, 0);
        checkVal("run_loadCount", load_count, 0);
        checkVal("run_we", ram_we, 0);
        checkVal("run_done", load_done, 0);
        cpu_CE_bar = 1'b0; cpu_mem_addr = 4'h5;
        #1;
        checkVal("run_ceFollow", ram_CE_bar, 0);
        checkVal("run_addrFollow", ram_addr, 4'h5);
        cpu_CE_bar = 1'b1; cpu_mem_addr = 4'hA;

        // Enter programming: hold rises on the 11th edge after the switch
        cycles(1);
        S3_ProgRun_sw = 1'b1;
        cycles(10);
        @(negedge base_clock);
        checkVal("prog_hold10", cpu_hold, 0);
        @(negedge base_clock);
        checkVal("prog_hold11", cpu_hold, 1);
        cycles(1);

        manualWrite(4'h3, 8'h5C, 40, "man1");

        // Bouncy button
        q0 = wrQ.size();
        repeat (10) begin
            S4_Write_pb = ~S4_Write_pb;
            cycles(3);
        end
        S4_Write_pb = 1'b0;
        cycles(14);
        checkVal("bounce_nWrites", wrQ.size() - q0, 0);

        streamLoad(5, 5, 1'b1, 1'b0, "early");
        streamLoad(20, 0, 1'b0, 1'b0, "ovf");

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 0) begin
                manualWrite(4'($urandom), 8'($urandom), $urandom_range(12, 30), "rman");
            end else begin
                int lp;
                lp = $urandom_range(1, 20);
                streamLoad(20, (lp > 16) ? 0 : lp, 1'b0, 1'b1, "rstream");
            end
        end

        for (int i = 0; i < 16; i++)
            if (expSet[i]) checkVal("mem", obsMem[i], expMem[i]);

        // Abort: debounced switch falls while the 7th byte is offered
        q0 = wrQ.size();
        d0 = doneCnt;
        idx = 0;
        S3_ProgRun_sw = 1'b0;
        cycles(3);
        for (int cyc = 0; cyc < 14; cyc++) begin
            stream_valid = 1'b1;
            stream_data  = 8'(8'hA0 + idx);
            stream_last  = 1'b0;
            @(negedge base_clock);
            acc = stream_valid && stream_ready;
            cycles(1);
            if (acc) idx++;
        end
        stream_valid = 1'b0;
        cycles(2);
        checkVal("abort_accepted", idx, 7);
        checkVal("abort_loadCount", load_count, 7);
        checkVal("abort_nWrites", wrQ.size() - q0, 7);
        for (int i = 0; i < 7; i++)
            if (q0 + i < wrQ.size()) checkVal("abort_wr", wrQ[q0 + i], {4'(i), 8'(8'hA0 + i)});
        checkVal("abort_nDone", doneCnt - d0, 0);
        checkVal("abort_hold", cpu_hold, 0);
        checkVal("abort_addr", ram_addr, cpu_mem_addr);
        checkVal("abort_ce", ram_CE_bar, cpu_CE_bar);

        // Reset in the middle of a stream load
        S3_ProgRun_sw = 1'b1;
        cycles(13);
        stream_valid = 1'b1;
        stream_data  = 8'h77;
        cycles(5);
        checkVal("clrPre_loadCount", load_count, 4);
        CLR = 1'b1;
        #1;
        checkVal("clr_loadCount", load_count, 0);
        checkVal("clr_ready", stream_ready, 0);
        checkVal("clr_hold", cpu_hold, 0);
        checkVal("clr_we", ram_we, 0);
        checkVal("clr_ce", ram_CE_bar, cpu_CE_bar);
        stream_valid = 1'b0;
        cycles(2);
        CLR = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
